// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU results and buffered load responses onto the
// single register-file write port, and tracks outstanding writes per register.
module writeback_arbiter #(
    parameter int unsigned LD_DEPTH     = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic [31:0] pending,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int unsigned PW = $clog2(LD_DEPTH);
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ld_entry_t;

    ld_entry_t       mem_q [LD_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     count_q, count_d;
    logic [CW-1:0]   starve_q, starve_d;
    logic [31:0]     pending_q, pending_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [31:0]     rf_wdata_q, rf_wdata_d;

    logic            fifo_empty, push, pop, alu_win;
    ld_entry_t       head;

    assign fifo_empty = (count_q == '0);
    assign ld_ready   = (count_q != (PW+1)'(LD_DEPTH));
    assign push       = ld_valid && ld_ready;
    assign alu_stall  = (starve_q == CW'(STARVE_LIMIT));
    // A stalled ALU never wins, so the FIFO is guaranteed the slot that cycle.
    assign alu_win    = alu_valid && !alu_stall;
    assign pop        = !alu_win && (!fifo_empty || push);
    // Empty FIFO lets an incoming load go straight to the output registers.
    assign head       = fifo_empty ? ld_entry_t'{rd: ld_rd, data: ld_data} : mem_q[rd_ptr_q];

    always_comb begin
        count_d    = count_q + (PW+1)'(push) - (PW+1)'(pop);
        starve_d   = starve_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        pending_d  = pending_q;

        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (alu_win) begin
            starve_d = starve_q + CW'(1);
        end

        if (alu_win) begin
            rf_we_d    = (alu_rd != '0);
            rf_waddr_d = alu_rd;
            rf_wdata_d = alu_data;
        end else if (pop) begin
            rf_we_d    = (head.rd != '0);
            rf_waddr_d = head.rd;
            rf_wdata_d = head.data;
        end

        // Clear on the presented write first so a same-cycle reissue wins.
        if (rf_we_q) begin
            pending_d[rf_waddr_q] = 1'b0;
        end
        if (issue_valid && issue_rd != '0) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ld_entry_t'{rd: ld_rd, data: ld_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            pending_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q    <= count_d;
            starve_q   <= starve_d;
            pending_q  <= pending_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign pending  = pending_q;
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, ALU path, collisions, FIFO fill
// with starvation stall, rd==0 handling, scoreboard races and mid-run reset.
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] pending;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_arbiter #(.LD_DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_stall  (alu_stall),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .pending    (pending),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        ld_valid    = 1'b0;
        ld_rd       = '0;
        ld_data     = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
    endtask

    initial begin
        idle_inputs();
        rst_n   = 1'b0;
        ld_valid = 1'b1;
        ld_rd    = 5'd5;
        ld_data  = 32'h0000_0505;
        #2;
        check("rst_ld_ready", ld_ready, 1);
        check("rst_pending", pending, 0);
        check("rst_we", rf_we, 0);
        check("rst_stall", alu_stall, 0);
        step();
        step();
        check("rst_we_held", rf_we, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);

        rst_n = 1'b1;
        check("rel_we_before_edge", rf_we, 0);
        step();
        check("first_ld_we", rf_we, 1);
        check("first_ld_waddr", rf_waddr, 5);
        check("first_ld_wdata", rf_wdata, 32'h0000_0505);
        check("first_ld_count", dut.count_q, 0);
        ld_valid = 1'b0;
        step();
        check("first_ld_we_off", rf_we, 0);
        check("first_ld_waddr_hold", rf_waddr, 5);

        // ALU only, with scoreboard tracking of x3
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        step();
        check("alu_pend_set", pending, 32'h0000_0008);
        issue_valid = 1'b0;
        alu_valid   = 1'b1;
        alu_rd      = 5'd3;
        alu_data    = 32'hDEAD_BEEF;
        step();
        check("alu_we", rf_we, 1);
        check("alu_waddr", rf_waddr, 3);
        check("alu_wdata", rf_wdata, 32'hDEAD_BEEF);
        check("alu_pend_still", pending, 32'h0000_0008);
        alu_valid = 1'b0;
        step();
        check("alu_we_off", rf_we, 0);
        check("alu_pend_clr", pending, 0);
        check("alu_wdata_hold", rf_wdata, 32'hDEAD_BEEF);

        // Collision: ALU beats load in the same cycle
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h0000_0011;
        ld_valid  = 1'b1; ld_rd  = 5'd2; ld_data  = 32'h0000_0055;
        step();
        check("col_alu_we", rf_we, 1);
        check("col_alu_waddr", rf_waddr, 1);
        check("col_alu_wdata", rf_wdata, 32'h0000_0011);
        check("col_count1", dut.count_q, 1);
        idle_inputs();
        step();
        check("col_ld_we", rf_we, 1);
        check("col_ld_waddr", rf_waddr, 2);
        check("col_ld_wdata", rf_wdata, 32'h0000_0055);
        check("col_count0", dut.count_q, 0);
        step();
        check("col_idle_we", rf_we, 0);

        // Fill: ALU busy every cycle while five loads arrive
        for (int unsigned i = 0; i < 4; i++) begin
            check("fill_ready", ld_ready, 1);
            check("fill_stall_low", alu_stall, 0);
            alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_data = 32'hC0 + i;
            ld_valid  = 1'b1; ld_rd  = 5'(10 + i); ld_data  = 32'hA0 + i;
            step();
            check("fill_alu_waddr", rf_waddr, 20 + i);
            check("fill_alu_wdata", rf_wdata, 32'hC0 + i);
            check("fill_count", dut.count_q, i + 1);
        end
        check("full_ready", ld_ready, 0);
        check("full_stall", alu_stall, 1);
        alu_valid = 1'b0;
        ld_rd = 5'd14; ld_data = 32'hA4;
        step();
        check("stall_fifo_we", rf_we, 1);
        check("stall_fifo_waddr", rf_waddr, 10);
        check("stall_fifo_wdata", rf_wdata, 32'hA0);
        check("stall_drop", alu_stall, 0);
        check("stall_ready", ld_ready, 1);
        check("stall_count", dut.count_q, 3);
        alu_valid = 1'b1; alu_rd = 5'd24; alu_data = 32'hC4;
        step();
        check("refill_waddr", rf_waddr, 24);
        check("refill_count", dut.count_q, 4);
        check("refill_ready", ld_ready, 0);
        check("refill_stall", alu_stall, 0);
        idle_inputs();
        for (int unsigned i = 1; i < 5; i++) begin
            step();
            check("drain_we", rf_we, 1);
            check("drain_waddr", rf_waddr, 10 + i);
            check("drain_wdata", rf_wdata, 32'hA0 + i);
        end
        step();
        check("drain_done_we", rf_we, 0);
        check("drain_done_count", dut.count_q, 0);

        // rd == 0 from both sources
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1;
        ld_valid  = 1'b1; ld_rd  = 5'd0; ld_data  = 32'h2;
        issue_valid = 1'b1; issue_rd = 5'd0;
        step();
        check("rd0_alu_we", rf_we, 0);
        check("rd0_count", dut.count_q, 1);
        check("rd0_pend", pending, 0);
        idle_inputs();
        step();
        check("rd0_ld_we", rf_we, 0);
        check("rd0_drained", dut.count_q, 0);
        check("rd0_pend2", pending, 0);

        // Scoreboard race: reissue x7 in the cycle its write is presented
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        check("race_pend_set", pending, 32'h0000_0080);
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7777_7777;
        step();
        check("race_we", rf_we, 1);
        check("race_waddr", rf_waddr, 7);
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        check("race_pend_kept", pending, 32'h0000_0080);
        issue_valid = 1'b0;
        step();
        check("race_pend_still", pending, 32'h0000_0080);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7;
        step();
        alu_valid = 1'b0;
        step();
        check("race_pend_final_clr", pending, 0);

        // Reset mid-operation discards queue and pending bits
        issue_valid = 1'b1; issue_rd = 5'd9;
        alu_valid = 1'b1; alu_rd = 5'd25; alu_data = 32'h25;
        ld_valid  = 1'b1; ld_rd  = 5'd15; ld_data  = 32'h15;
        step();
        check("mid_pend", pending, 32'h0000_0200);
        check("mid_count1", dut.count_q, 1);
        issue_valid = 1'b0;
        alu_rd = 5'd26; ld_rd = 5'd16;
        step();
        check("mid_count2", dut.count_q, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pend", pending, 0);
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_count", dut.count_q, 0);
        check("mid_rst_ready", ld_ready, 1);
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_we1", rf_we, 0);
        step();
        check("post_rst_we2", rf_we, 0);
        check("post_rst_pend", pending, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
